// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the ADC-to-UART frame sequencer.
// Select codes map byte order onto the two-channel byte mux.
package tx_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam logic [1:0] SEL_DMCH0 = 2'b00;
    localparam logic [1:0] SEL_DLCH0 = 2'b01;
    localparam logic [1:0] SEL_DMCH1 = 2'b10;
    localparam logic [1:0] SEL_DLCH1 = 2'b11;

    localparam int unsigned FRAME_BYTES   = 4;
    localparam logic [1:0]  LAST_BYTE_IDX = 2'(FRAME_BYTES - 1);

    // One extra bit so the larger load value always fits, even for powers of two.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/tx_frame_sequencer_if.sv
// Handshake bundle between the sequencer, the ADC capture logic, the byte mux and the UART.
// master = sequencer side, slave = surrounding logic.
interface tx_frame_sequencer_if;

    logic       start_i;
    logic       tx_done_i;
    logic [1:0] sel_o;
    logic       tx_start_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       overrun_o;
    logic       timeout_o;

    modport master (
        input  start_i,
        input  tx_done_i,
        output sel_o,
        output tx_start_o,
        output busy_o,
        output frame_done_o,
        output overrun_o,
        output timeout_o
    );

    modport slave (
        output start_i,
        output tx_done_i,
        input  sel_o,
        input  tx_start_o,
        input  busy_o,
        input  frame_done_o,
        input  overrun_o,
        input  timeout_o
    );

endinterface

// File: rtl/tx_frame_sequencer_timer.sv
// Loadable down-counter shared by the WAIT timeout and the inter-byte GAP.
// A load of N keeps expired_o low for N-1 cycles, so the owning state lasts N cycles.
module seq_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign expired_o = (cnt_q <= Width'(1));

endmodule

// File: rtl/tx_frame_sequencer.sv
// Walks the ADC byte mux through ch0 MSB/LSB, ch1 MSB/LSB on each sample-ready pulse,
// issuing one UART start per byte, waiting for done, then an optional inter-byte gap.
module tx_frame_sequencer
    import tx_seq_pkg::*;
#(
    parameter int unsigned GapCycles     = 16,
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tx_frame_sequencer_if.master bus
);

    localparam int unsigned        TimerW      = timer_width(GapCycles, TimeoutCycles);
    localparam logic [TimerW-1:0]  GapLoad     = TimerW'(GapCycles);
    localparam logic [TimerW-1:0]  TimeoutLoad = TimerW'(TimeoutCycles);

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               start_q;
    logic               tmr_load;
    logic [TimerW-1:0]  tmr_val;
    logic               tmr_expired;

    logic [1:0]         sel_d;
    logic               tx_start_d;
    logic               busy_d;
    logic               frame_done_d;
    logic               overrun_d;
    logic               timeout_d;

    seq_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // start_i is captured only while idle; a start seen while busy becomes an overrun instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            start_q          <= 1'b0;
            bus.sel_o        <= SEL_DMCH0;
            bus.tx_start_o   <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.frame_done_o <= 1'b0;
            bus.overrun_o    <= 1'b0;
            bus.timeout_o    <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            start_q          <= bus.start_i & ~bus.busy_o;
            bus.sel_o        <= sel_d;
            bus.tx_start_o   <= tx_start_d;
            bus.busy_o       <= busy_d;
            bus.frame_done_o <= frame_done_d;
            bus.overrun_o    <= overrun_d;
            bus.timeout_o    <= timeout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = TimeoutLoad;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (start_q) state_d = ST_SETUP;
            end
            ST_SETUP: state_d = ST_SEND;
            ST_SEND: begin
                state_d  = ST_WAIT;
                tmr_load = 1'b1;
                tmr_val  = TimeoutLoad;
            end
            ST_WAIT: begin
                // A done arriving on the expiry cycle still completes the byte.
                if (bus.tx_done_i) begin
                    if (idx_q == LAST_BYTE_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        if (GapCycles == 0) begin
                            state_d = ST_SETUP;
                        end else begin
                            state_d  = ST_GAP;
                            tmr_load = 1'b1;
                            tmr_val  = GapLoad;
                        end
                    end
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            ST_GAP: begin
                if (tmr_expired) state_d = ST_SETUP;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        sel_d = SEL_DMCH0;
        unique case (idx_d)
            2'd0:    sel_d = SEL_DMCH0;
            2'd1:    sel_d = SEL_DLCH0;
            2'd2:    sel_d = SEL_DMCH1;
            default: sel_d = SEL_DLCH1;
        endcase
        tx_start_d   = (state_d == ST_SEND);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
        timeout_d    = (state_q == ST_WAIT) && !bus.tx_done_i && tmr_expired;
        overrun_d    = (bus.start_i && bus.busy_o) || (start_q && (state_q != ST_IDLE));
    end

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Sequences the two-channel ADC byte multiplexer onto the UART transmitter. On each sample-ready pulse it walks the mux select through ch0 MSB, ch0 LSB, ch1 MSB, ch1 LSB. For each byte it issues one transmit-start pulse, waits for the transmitter's done pulse, then inserts a programmable inter-byte gap. It sits between the ADC capture logic, the data mux select input and the UART tx start/done handshake.

## Interface
- `GapCycles`, default 16: idle cycles inserted between consecutive bytes of a frame; 0 is legal.
- `TimeoutCycles`, default 4096: maximum cycles spent waiting for `tx_done_i` before aborting the frame; must be ≥ 1.
- `clk_i`, input, 1: system clock, single clock domain.
- `rst_ni`, input, 1: reset, asynchronous assert, active-low.
- `start_i`, input, 1: sample-ready pulse from the ADC capture logic.
- `tx_done_i`, input, 1: one-cycle pulse from the UART at the end of a byte.
- `sel_o`, output, 2: mux select; 00 = ch0 MSB, 01 = ch0 LSB, 10 = ch1 MSB, 11 = ch1 LSB.
- `tx_start_o`, output, 1: one-cycle transmit request to the UART.
- `busy_o`, output, 1: frame in progress.
- `frame_done_o`, output, 1: one-cycle pulse after all 4 bytes are sent.
- `overrun_o`, output, 1: one-cycle pulse when `start_i` arrives while busy.
- `timeout_o`, output, 1: one-cycle pulse when a frame is aborted on timeout.

## Operation
- All outputs are registered. Reset value of every output is 0. The state resets to IDLE and the byte index to 0.
- FSM states: IDLE, SETUP, SEND, WAIT, GAP, DONE.
- **IDLE**
  - `busy_o`=0 and `sel_o`=00.
  - If `start_i`=1: set index to 0, set `busy_o` to 1, go to SETUP.
- **SETUP**
  - One settle cycle with `sel_o` = index, so the mux output is stable before the start pulse.
  - Go to SEND.
- **SEND**
  - `tx_start_o`=1 for exactly this cycle.
  - Load the timer with `TimeoutCycles`, go to WAIT.
  - A `tx_done_i` in this cycle is ignored.
- **WAIT**, on `tx_done_i`=1:
  - If index = 3, go to DONE.
  - Otherwise increment the index. Go to GAP (timer loaded with `GapCycles`), or directly to SETUP if `GapCycles`=0.
- **WAIT**, on timer expiry without done:
  - Pulse `timeout_o`, clear index and `sel_o` to 0, go to IDLE.
  - If `tx_done_i` and expiry occur in the same cycle, done wins.
- **GAP**
  - Count down `GapCycles` cycles, then go to SETUP.
  - `sel_o` already shows the new index.
- **DONE**
  - Pulse `frame_done_o`, clear index and `sel_o` to 00, go to IDLE.
  - `busy_o` stays 1 in this cycle and falls on the next edge.
- **Overrun**
  - `start_i`=1 while `busy_o`=1 (including the DONE cycle) is dropped.
  - `overrun_o` pulses on the next cycle. The frame in progress is unaffected.
  - A `start_i` on the first IDLE cycle after DONE is accepted.
- The index is a 2-bit counter that never wraps: the step from 3 is always DONE.
- Reset mid-frame returns everything to reset values immediately. No partial frame is resumed.

## Timing
- `start_i` sampled at edge 0:
  - SETUP after edge 1.
  - `tx_start_o` high between edges 2 and 3, with `sel_o`=00 held since edge 1.
- Per byte: 1 SETUP + 1 SEND + WAIT duration + `GapCycles` (GAP on bytes 0-2 only).
- `frame_done_o` is high in the cycle after the edge that samples the 4th `tx_done_i`.
- With zero UART latency (`tx_done_i` on the first WAIT cycle) and `GapCycles`=G, `start_i` to `frame_done_o` is 13 + 3G cycles.
- `sel_o` changes only on entry to GAP/SETUP (or to 00 in DONE/timeout). It never changes in SEND or WAIT.

## Structure
- Shared package `tx_seq_pkg`:
  - State enum/localparams.
  - Select constants `SEL_DMCH0`, `SEL_DLCH0`, `SEL_DMCH1`, `SEL_DLCH1`.
  - Frame byte count (4).
- Sub-module `seq_timer`:
  - Loadable down-counter, width = `$clog2` of max(`GapCycles`, `TimeoutCycles`) + 1.
  - Load value input, load strobe, and an `expired_o` flag.
  - Shared between GAP and WAIT.

## Test plan
- **Nominal frame:** `GapCycles`=2, `start_i` pulse, UART model returns `tx_done_i` 10 cycles after each `tx_start_o`.
  - Expect `sel_o` sequence 00, 01, 10, 11.
  - Expect exactly 4 `tx_start_o` pulses, each preceded by a stable `sel_o` for ≥ 1 cycle.
  - Expect one `frame_done_o`; `busy_o` then drops.
- **Overrun:** `start_i` asserted during byte 2 and again in the DONE cycle.
  - Expect two `overrun_o` pulses.
  - Frame completes normally; no second frame starts.
- **Timeout:** `TimeoutCycles`=8, withhold `tx_done_i` after byte 1.
  - Expect `timeout_o` 8 cycles after the 2nd `tx_start_o`.
  - Expect `sel_o`=00, `busy_o`=0, no `frame_done_o`.
  - A new `start_i` then runs a full frame.
- **Gap zero and back-to-back:** `GapCycles`=0, `tx_done_i` on the first WAIT cycle.
  - Expect 13 cycles from `start_i` to `frame_done_o`.
  - `start_i` on the first IDLE cycle after DONE is accepted with no overrun.
- **Async reset mid-frame:** deassert `rst_ni` during WAIT of byte 3.
  - All outputs are 0 immediately, without a clock edge.
  - After release, a stray `tx_done_i` causes no `tx_start_o` and no `frame_done_o`.
